// File: rtl/reset_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_collector_pkg
//  Description : Shared types and limits for the reset request collector.
//  Revision    : 1.0  initial release
// ============================================================================
package reset_collector_pkg;

  // Largest supported number of request sources.
  localparam int RRC_MAX_SRC = 32;

  // Collector FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } rrc_state_e;

endpackage : reset_collector_pkg
`default_nettype wire

// File: rtl/reset_request_collector.sv
`default_nettype none
// ============================================================================
//  Module      : reset_request_collector
//  Description : Merges level reset requests from N_SRC sinks into one
//                stretched, flop-driven reset. Records which sources caused
//                resets (sticky cause) and acknowledges every participant of
//                an episode when the merged reset is released.
//  Revision    : 1.0  initial release
// ============================================================================
module reset_request_collector
  import reset_collector_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             cause_clear,
  output logic             out_reset,
  output logic             busy,
  output logic [N_SRC-1:0] ack,
  output logic [N_SRC-1:0] cause
);

  // Counter is sized to hold HOLD_CYCLES so it can never wrap while in HOLD.
  localparam int             CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);

  // Parameter sanity checks, evaluated at elaboration.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_request_collector: HOLD_CYCLES must be >= 1");
  end
  if ((N_SRC < 1) || (N_SRC > RRC_MAX_SRC)) begin : g_bad_nsrc
    $error("reset_request_collector: N_SRC must be within 1..32");
  end

  rrc_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [N_SRC-1:0] episode_q;
  logic [N_SRC-1:0] ack_q;
  logic [N_SRC-1:0] cause_q;
  logic [N_SRC-1:0] cause_d;
  logic             out_reset_q;
  logic             busy_q;

  // Episode FSM: stretch the merged reset, track participants, pulse ack on release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      out_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      episode_q   <= '0;
      ack_q       <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            episode_q   <= req;
            out_reset_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        HOLD: begin
          // Requests dropping here do not shorten the stretch; late joiners are recorded.
          episode_q <= episode_q | req;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (|req) begin
            episode_q <= episode_q | req;
          end else begin
            state_q     <= IDLE;
            out_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= episode_q;
            episode_q   <= '0;
          end
        end
        default: begin
          // Unreachable encoding: recover by starting a fresh stretch.
          state_q     <= HOLD;
          cnt_q       <= '0;
          out_reset_q <= 1'b1;
          busy_q      <= 1'b1;
          episode_q   <= '0;
        end
      endcase
    end
  end

  // Sticky cause: new requests win over a clear arriving in the same cycle.
  always_comb begin
    cause_d = cause_clear ? req : (cause_q | req);
  end

  // Cause register; wiped by block reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign out_reset = out_reset_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign cause     = cause_q;

endmodule : reset_request_collector
`default_nettype wire

// File: tb/tb_reset_request_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_request_collector
//  Description : Self-checking bench for reset_request_collector. A reference
//                model built on "episode age" (edges since the episode began)
//                predicts every output each cycle; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reset_request_collector;

  localparam int N = 8;
  localparam int H = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         cause_clear;
  logic         out_reset;
  logic         busy;
  logic [N-1:0] ack;
  logic [N-1:0] cause;

  int errors = 0;
  int checks = 0;

  reset_request_collector #(
    .N_SRC      (N),
    .HOLD_CYCLES(H)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .req        (req),
    .cause_clear(cause_clear),
    .out_reset  (out_reset),
    .busy       (busy),
    .ack        (ack),
    .cause      (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. An episode is "active" from its start edge until the
  // first edge at which it is at least H edges old and no request is present.
  bit           m_valid = 1'b0;
  bit           m_active;
  int           m_age;
  logic [N-1:0] m_ep;
  logic [N-1:0] m_ack;
  logic [N-1:0] m_cause;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b1;
      m_age    = 0;
      m_ep     = '0;
      m_ack    = '0;
      m_cause  = '0;
    end else if (m_valid) begin
      m_ack = '0;
      if (!m_active) begin
        if (req != 0) begin
          m_active = 1'b1;
          m_age    = 0;
          m_ep     = req;
        end
      end else if (m_age >= H && req == 0) begin
        m_active = 1'b0;
        m_ack    = m_ep;
        m_ep     = '0;
      end else begin
        m_ep = m_ep | req;
        if (m_age < H) m_age++;
      end
      m_cause = cause_clear ? req : (m_cause | req);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("out_reset", 32'(out_reset), 32'(m_active));
      chk("busy",      32'(busy),      32'(m_active));
      chk("ack",       32'(ack),       32'(m_ack));
      chk("cause",     32'(cause),     32'(m_cause));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  int           n;
  int           acks;
  logic [N-1:0] ack_val;

  initial begin
    rst         = 1'b1;
    req         = '0;
    cause_clear = 1'b0;

    // Power-on: three reset edges, then a stretch with no requests.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("por_out_reset", 32'(out_reset), 32'd1);
    chk("por_cause", 32'(cause), 32'd0);
    n = 0;
    while (out_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("por_stretch_len", 32'(n), 32'(H + 1));
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_ack", 32'(ack), 32'd0);
    chk("por_cause_end", 32'(cause), 32'd0);

    // Single one-cycle request.
    repeat (2) @(negedge clk);
    req = 8'h04;
    @(negedge clk);
    req = '0;
    n = 0;
    while (out_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("single_len", 32'(n), 32'd5);
    chk("single_ack", 32'(ack), 32'h04);
    chk("single_cause", 32'(cause), 32'h04);
    @(negedge clk);
    chk("single_ack_one_cycle", 32'(ack), 32'd0);

    // Long request on source 0.
    req = 8'h01;
    repeat (20) @(negedge clk);
    chk("long_held", 32'(out_reset), 32'd1);
    req = '0;
    @(negedge clk);
    chk("long_release", 32'(out_reset), 32'd0);
    chk("long_ack", 32'(ack), 32'h01);

    // Clear cause with no request pending.
    @(negedge clk);
    cause_clear = 1'b1;
    @(negedge clk);
    cause_clear = 1'b0;
    chk("clear_cause", 32'(cause), 32'd0);

    // Overlap / late joiner: one episode, one ack of 0x81.
    acks    = 0;
    ack_val = '0;
    req = 8'h01;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 8'h80;
    repeat (9) @(negedge clk);
    req = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        acks++;
        ack_val = ack;
      end
    end
    chk("late_ack_count", 32'(acks), 32'd1);
    chk("late_ack_val", 32'(ack_val), 32'h81);
    chk("late_cause", 32'(cause), 32'h81);

    // Clear racing a new request: the request wins.
    cause_clear = 1'b1;
    req         = 8'h02;
    @(negedge clk);
    cause_clear = 1'b0;
    req         = '0;
    chk("race_cause", 32'(cause), 32'h02);
    wait_idle();

    // Mid-episode reset while DRAIN is held by req[4].
    req = 8'h10;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_reset", 32'(out_reset), 32'd1);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_cause", 32'(cause), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_held", 32'(out_reset), 32'd1);
    end
    req = '0;
    @(negedge clk);
    chk("midrst_release", 32'(out_reset), 32'd0);
    wait_idle();

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        req = N'($urandom_range(0, 255)) & N'($urandom_range(0, 255));
      else
        req = '0;
      cause_clear = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst         = 1'b0;
    req         = '0;
    cause_clear = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reset_request_collector
`default_nettype wire
